// File: rtl/branch_predictor_pkg.sv
// Shared decode constants and branch-predictor counter encoding.
// Saturating 2-bit counter states live next to the branch opcodes.
package branch_predictor_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predictor_bp_cache.sv
// Direct-mapped {valid, tag, data} store: bypassed read port,
// raw peek port for the writer, one sync write, async clear.
module bp_cache #(
    parameter int LINES = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [1:0]       rd_data_o,
    input  logic [IDX_W-1:0] pk_idx_i,
    output logic             pk_valid_o,
    output logic [TAG_W-1:0] pk_tag_o,
    output logic [1:0]       pk_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [1:0]       wr_data_i
);

    logic             valid_q [LINES];
    logic [TAG_W-1:0] tag_q   [LINES];
    logic [1:0]       data_q  [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= 2'd0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            tag_q[wr_idx_i]   <= wr_tag_i;
            data_q[wr_idx_i]  <= wr_data_i;
        end
    end

    // A same-index write is forwarded so the reader sees post-edge state.
    always_comb begin
        rd_valid_o = valid_q[rd_idx_i];
        rd_tag_o   = tag_q[rd_idx_i];
        rd_data_o  = data_q[rd_idx_i];
        if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
            rd_valid_o = 1'b1;
            rd_tag_o   = wr_tag_i;
            rd_data_o  = wr_data_i;
        end
    end

    assign pk_valid_o = valid_q[pk_idx_i];
    assign pk_tag_o   = tag_q[pk_idx_i];
    assign pk_data_o  = data_q[pk_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Branch history table with 2-bit counters, trained from execute,
// queried from decode, plus branch/mispredict perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int LINES    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] guess_pc,
    input  logic                guess_valid,
    output logic                guess_taken,
    input  logic [PC_WIDTH-1:0] check_pc,
    input  logic                check_valid,
    input  logic                check_taken,
    input  logic                check_mispred,
    output logic [31:0]         br_count,
    output logic [31:0]         mispred_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = PC_WIDTH - IDX_W - 2;

    logic [IDX_W-1:0] g_idx, c_idx;
    logic [TAG_W-1:0] g_tag, c_tag;
    logic             rd_valid, pk_valid;
    logic [TAG_W-1:0] rd_tag, pk_tag;
    logic [1:0]       rd_data, pk_data;
    logic             c_hit;
    logic [1:0]       wr_data;
    logic [31:0]      br_q, br_d, mis_q, mis_d;
    logic             unused_pc_lsb;

    assign g_idx = guess_pc[IDX_W+1:2];
    assign g_tag = guess_pc[PC_WIDTH-1:IDX_W+2];
    assign c_idx = check_pc[IDX_W+1:2];
    assign c_tag = check_pc[PC_WIDTH-1:IDX_W+2];
    assign unused_pc_lsb = ^{guess_pc[1:0], check_pc[1:0]};

    bp_cache #(
        .LINES(LINES),
        .IDX_W(IDX_W),
        .TAG_W(TAG_W)
    ) u_cache (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx_i  (g_idx),
        .rd_valid_o(rd_valid),
        .rd_tag_o  (rd_tag),
        .rd_data_o (rd_data),
        .pk_idx_i  (c_idx),
        .pk_valid_o(pk_valid),
        .pk_tag_o  (pk_tag),
        .pk_data_o (pk_data),
        .wr_en_i   (check_valid),
        .wr_idx_i  (c_idx),
        .wr_tag_i  (c_tag),
        .wr_data_i (wr_data)
    );

    // Misses allocate weakly toward the observed outcome.
    assign c_hit   = pk_valid && (pk_tag == c_tag);
    assign wr_data = c_hit ? ctr_next(pk_data, check_taken)
                   : (check_taken ? CTR_WT : CTR_WNT);

    assign guess_taken = guess_valid && rd_valid
                      && (rd_tag == g_tag) && rd_data[1];

    always_comb begin
        br_d  = br_q;
        mis_d = mis_q;
        if (check_valid) begin
            br_d = br_q + 32'd1;
            if (check_mispred) mis_d = mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q  <= 32'd0;
            mis_q <= 32'd0;
        end else begin
            br_q  <= br_d;
            mis_q <= mis_d;
        end
    end

    assign br_count      = br_q;
    assign mispred_count = mis_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch history table with 2-bit saturating counters. It serves the prediction request from decode (stage 1) and is trained by branch resolution from execute (stage 2). It supplies the taken/not-taken guess that stage-1 control uses when `bp_enable` is high. It also keeps branch and mispredict performance counters for the CSR path.

## Interface
- `PC_WIDTH`, 32, PC width in bits.
- `LINES`, 8, number of table entries; must be a power of two, ≥2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `guess_pc`  in  PC_WIDTH  PC of the stage-1 instruction.
- `guess_valid`  in  1  stage-1 instruction is a conditional branch.
- `guess_taken`  out  1  predicted taken.
- `check_pc`  in  PC_WIDTH  PC of the resolved branch in stage 2.
- `check_valid`  in  1  a conditional branch resolves this cycle.
- `check_taken`  in  1  actual outcome.
- `check_mispred`  in  1  stage-2 outcome differed from the prediction that was used.
- `br_count`  out  32  resolved branches since reset.
- `mispred_count`  out  32  mispredictions since reset.

## Operation
- Index = `pc[IDX+1:2]` with IDX = log2(LINES); tag = `pc[PC_WIDTH-1:IDX+2]`. `pc[1:0]` is ignored.
- Entry = {valid, tag, ctr[1:0]}.
- Counter encoding: SNT=0, WNT=1, WT=2, ST=3. Predict taken iff ctr[1]=1.
- Lookup:
  - `guess_taken` = `guess_valid` AND entry valid AND tag match AND ctr[1].
  - Miss or `guess_valid`=0 gives 0.
- Update, on a rising edge with `check_valid`=1:
  - Hit: ctr saturating +1 if `check_taken`, −1 otherwise. ST stays ST; SNT stays SNT.
  - Miss (invalid entry or tag mismatch): allocate. Set valid=1, write the new tag, ctr = WT if taken, WNT if not. The previous occupant is discarded.
- With `check_valid`=0, table contents are unchanged.
- Same-cycle bypass: when `guess_valid` and `check_valid` are both high and `guess_pc` and `check_pc` map to the same index, `guess_taken` reflects the entry state after this cycle's update. Tag compare uses the post-update tag.
- Perf counters:
  - `br_count` += 1 on each `check_valid`.
  - `mispred_count` += 1 when `check_valid` AND `check_mispred`. `check_mispred` is ignored when `check_valid`=0.
  - Both counters are 32-bit and wrap from 0xFFFFFFFF to 0.

## Timing
- Lookup is combinational: `guess_taken` is valid in the same cycle as `guess_pc`.
- Update has one-cycle latency: a lookup one cycle after the update edge sees the new state without needing the bypass.
- Reset: `rst_n` low asynchronously clears every valid bit, every ctr (to SNT), `br_count` and `mispred_count`. `guess_taken` therefore reads 0 while in reset.
- Reset asserted mid-operation discards any in-flight update. The first edge after deassertion processes inputs normally.
- No stall input: the pipeline holds `check_valid` low during stalls and flushes so that no branch is double-counted.

## Structure
- Shared package or header holds the counter constants (SNT, WNT, WT, ST) next to the existing opcode defines.
- Sub-module `bp_cache`:
  - Arrays: LINES × (valid, tag, 2-bit data).
  - One combinational read port with a write-bypass.
  - One synchronous write port with asynchronous clear.
- Top level holds the index/tag split, the saturating-counter next-state logic and the perf counters.

## Test plan
- Reset then lookup: `guess_pc`=0x100, `guess_valid`=1 → `guess_taken`=0; `br_count`=`mispred_count`=0.
- Allocate and train (each update is one rising edge with `check_valid`=1 at PC 0x100; the first allocates):
  - one taken → predict 1 (WT);
  - then two not-taken → predict 0 (SNT).
- Saturation at 0x100:
  - five consecutive taken then one not-taken → predict 1 (ST→WT);
  - a further not-taken → predict 0.
- Aliasing with LINES=8: train 0x100 to ST, then lookup 0x120 → 0 (tag miss).
  - Update 0x120 not-taken → 0x120 predicts 0 (WNT).
  - Lookup 0x100 → 0 (entry evicted).
- Bypass: 0x200 at WNT; same cycle `check_valid`=1, taken, `guess_pc`=0x200 → `guess_taken`=1 before the edge.
- Counters and reset:
  - 10 resolutions, 3 with `check_mispred` → `br_count`=10, `mispred_count`=3;
  - then pulse `rst_n` low between edges → all outputs 0 immediately.
